// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: constants shared by the ALU issue controller and the alu.
//   - ALU_control codes understood by the combinational alu
//   - ALUOp codes produced by the main decoder
//   - R-type funct field values
//   - FSM state encoding of the issue controller
package mips_alu_pkg;

  // ALU_control codes (fixed by the alu implementation)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1101;
  localparam logic [3:0] ALU_SRL = 4'b1110;

  // ALUOp codes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw/sw address
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] ALUOP_OR    = 2'b11;  // ori

  // R-type funct values
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  // Issue controller FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct to ALU_control translation.
// Ports:
//   alu_op_i    [1:0]  ALUOp from the main decoder
//   funct_i     [5:0]  R-type funct field
//   alu_ctrl_o  [3:0]  ALU_control code for the alu
//   is_shift_o         operation is sll/srl (operand steering differs)
//   illegal_o          R-type funct not supported; op falls back to add
module alu_ctrl_decode
  import mips_alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       is_shift_o,
  output logic       illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    is_shift_o = 1'b0;
    illegal_o  = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_OR:  alu_ctrl_o = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD, FUNCT_ADDU: alu_ctrl_o = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: alu_ctrl_o = ALU_SUB;
          FUNCT_AND:             alu_ctrl_o = ALU_AND;
          FUNCT_OR:              alu_ctrl_o = ALU_OR;
          FUNCT_NOR:             alu_ctrl_o = ALU_NOR;
          FUNCT_SLT:             alu_ctrl_o = ALU_SLT;
          FUNCT_SLL: begin
            alu_ctrl_o = ALU_SLL;
            is_shift_o = 1'b1;
          end
          FUNCT_SRL: begin
            alu_ctrl_o = ALU_SRL;
            is_shift_o = 1'b1;
          end
          default: begin
            // Unknown funct still produces a result (add) so the
            // pipeline keeps flowing; the flag lets writeback trap it.
            alu_ctrl_o = ALU_ADD;
            illegal_o  = 1'b1;
          end
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the combinational alu.
// Accepts one decoded op per in_valid/in_ready handshake, registers the
// ALU_control code and steered operands, lets the alu evaluate for one
// cycle, registers the result and returns it via res_valid/res_ready.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                operation handshake
//   in_alu_op, in_funct, in_shamt    decoded operation fields
//   in_rs_data, in_rt_data           source operands
//   read_data_1/2, shamt, ALU_control  drive the alu (registered)
//   ALU_result, zero                 alu outputs
//   res_valid/res_ready              result handshake
//   res_data, res_zero, res_illegal  registered result and flags
//   issue_count, illegal_count       saturating statistics
// WIDTH must be 32 to match the alu.
module alu_issue_ctrl
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alu_op,
  input  logic [5:0]       in_funct,
  input  logic [4:0]       in_shamt,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  output logic [WIDTH-1:0] read_data_1,
  output logic [WIDTH-1:0] read_data_2,
  output logic [4:0]       shamt,
  output logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] ALU_result,
  input  logic             zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_illegal,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e state_q, state_d;

  logic [3:0]       dec_ctrl;
  logic             dec_shift;
  logic             dec_illegal;
  logic             accept;

  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] rd1_q, rd2_q;
  logic [4:0]       shamt_q;
  logic             illegal_pend_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_zero_q;
  logic             res_illegal_q;
  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  alu_ctrl_decode u_decode (
    .alu_op_i   (in_alu_op),
    .funct_i    (in_funct),
    .alu_ctrl_o (dec_ctrl),
    .is_shift_o (dec_shift),
    .illegal_o  (dec_illegal)
  );

  assign accept = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: begin
        // Result pop and new accept may coincide (back-to-back issue)
        if (res_ready) state_d = in_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: begin
        res_valid = 1'b1;
        in_ready  = res_ready;
      end
      default: ;
    endcase
  end

  // ALU-facing registers: loaded only on accept, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q         <= ALU_ADD;
      rd1_q          <= '0;
      rd2_q          <= '0;
      shamt_q        <= '0;
      illegal_pend_q <= 1'b0;
    end else if (accept) begin
      ctrl_q         <= dec_ctrl;
      // The alu shifts its first operand, so rt is routed there for shifts
      rd1_q          <= dec_shift ? in_rt_data : in_rs_data;
      rd2_q          <= dec_shift ? '0 : in_rt_data;
      shamt_q        <= dec_shift ? in_shamt : 5'd0;
      illegal_pend_q <= dec_illegal;
    end
  end

  // Result registers: captured only at the EXEC->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_data_q    <= ALU_result;
      res_zero_q    <= zero;
      res_illegal_q <= illegal_pend_q;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
    end else if (accept) begin
      if (issue_cnt_q != CNT_MAX) issue_cnt_q <= issue_cnt_q + CNT_ONE;
      if (dec_illegal && (illegal_cnt_q != CNT_MAX))
        illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
    end
  end

  assign ALU_control   = ctrl_q;
  assign read_data_1   = rd1_q;
  assign read_data_2   = rd2_q;
  assign shamt         = shamt_q;
  assign res_data      = res_data_q;
  assign res_zero      = res_zero_q;
  assign res_illegal   = res_illegal_q;
  assign issue_count   = issue_cnt_q;
  assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural stand-in for the alu.
// Expected results are pushed to a queue at issue and popped on res_valid.
module tb_alu_issue_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_data, in_rt_data;
  logic [31:0] read_data_1, read_data_2;
  logic [4:0]  shamt;
  logic [3:0]  ALU_control;
  logic [31:0] ALU_result;
  logic        zero;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_zero, res_illegal;
  logic [CNT_W-1:0] issue_count, illegal_count;

  typedef struct {
    logic [31:0] d;
    logic        z;
    logic        il;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] exp_issue = '0;
  logic [CNT_W-1:0] exp_ill = '0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .shamt(shamt), .ALU_control(ALU_control),
    .ALU_result(ALU_result), .zero(zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_illegal(res_illegal),
    .issue_count(issue_count), .illegal_count(illegal_count)
  );

  // Behavioural model of the existing combinational alu
  always_comb begin
    case (ALU_control)
      4'b0000: ALU_result = read_data_1 & read_data_2;
      4'b0001: ALU_result = read_data_1 | read_data_2;
      4'b0010: ALU_result = read_data_1 + read_data_2;
      4'b0110: ALU_result = read_data_1 - read_data_2;
      4'b0111: ALU_result = ($signed(read_data_1) < $signed(read_data_2)) ? 32'd1 : 32'd0;
      4'b1100: ALU_result = ~(read_data_1 | read_data_2);
      4'b1101: ALU_result = read_data_1 << shamt;
      4'b1110: ALU_result = read_data_1 >> shamt;
      default: ALU_result = 32'd0;
    endcase
    zero = (ALU_result == 32'd0);
  end

  // Offer one op (entered and left #1 after a posedge), push its expectation
  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [3:0] exp_ctrl,
                       input logic [31:0] exp_d, input logic exp_z,
                       input logic exp_il);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; in_alu_op = op; in_funct = fn; in_shamt = sh;
    in_rs_data = rs; in_rt_data = rt;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.d = exp_d; e.z = exp_z; e.il = exp_il;
    exp_q.push_back(e);
    if (exp_issue != CNT_MAX) exp_issue++;
    if (exp_il && exp_ill != CNT_MAX) exp_ill++;
    total++;
    if (ALU_control !== exp_ctrl) begin
      bad++; $display("FAIL alu_control: got %b required %b", ALU_control, exp_ctrl);
    end
    total++;
    if (issue_count !== exp_issue) begin
      bad++; $display("FAIL issue_count: got %0d required %0d", issue_count, exp_issue);
    end
    total++;
    if (illegal_count !== exp_ill) begin
      bad++; $display("FAIL illegal_count: got %0d required %0d", illegal_count, exp_ill);
    end
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL res_valid_exec: got %b required 0", res_valid);
    end
    $display("issue op=%b funct=%h rs=%h rt=%h ctrl=%b", op, fn, rs, rt, ALU_control);
  endtask

  // Wait (bounded) for a result, compare against the queue head, pop it
  task automatic pop_result();
    int n = 0;
    exp_t e;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!res_valid) begin
      bad++; $display("FAIL result_timeout: res_valid=%b required 1", res_valid);
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL unexpected_result: data=%h required none", res_data);
      return;
    end
    e = exp_q.pop_front();
    total++;
    if (res_data !== e.d || res_zero !== e.z || res_illegal !== e.il) begin
      bad++;
      $display("FAIL result: got data=%h zero=%b ill=%b required data=%h zero=%b ill=%b",
               res_data, res_zero, res_illegal, e.d, e.z, e.il);
    end
    $display("result data=%h zero=%b ill=%b", res_data, res_zero, res_illegal);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_alu_op = 2'b00; in_funct = 6'h00; in_shamt = 5'd0;
    in_rs_data = '0; in_rt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: in_ready=%b res_valid=%b required 1/0", in_ready, res_valid);
    end
    total++;
    if (ALU_control !== 4'b0010) begin
      bad++; $display("FAIL reset_ctrl: got %b required 0010", ALU_control);
    end
    total++;
    if (res_data !== 32'd0 || read_data_1 !== 32'd0 || read_data_2 !== 32'd0 ||
        shamt !== 5'd0 || res_zero !== 1'b0 || res_illegal !== 1'b0) begin
      bad++; $display("FAIL reset_data: res_data=%h rd1=%h rd2=%h required 0", res_data, read_data_1, read_data_2);
    end
    total++;
    if (issue_count !== '0 || illegal_count !== '0) begin
      bad++; $display("FAIL reset_counts: %0d/%0d required 0/0", issue_count, illegal_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    issue(2'b10, 6'h20, 5'd0, 32'd13, 32'd5, 4'b0010, 32'd18, 1'b0, 1'b0);
    pop_result();
  endtask

  task automatic test_sub_zero();
    issue(2'b01, 6'h15, 5'd0, 32'd29, 32'd23, 4'b0110, 32'd6, 1'b0, 1'b0);
    pop_result();
    issue(2'b01, 6'h00, 5'd0, 32'd7, 32'd7, 4'b0110, 32'd0, 1'b1, 1'b0);
    pop_result();
  endtask

  task automatic test_logic();
    issue(2'b10, 6'h27, 5'd0, 32'd30, 32'd5, 4'b1100, 32'hFFFFFFE0, 1'b0, 1'b0);
    pop_result();
    issue(2'b10, 6'h2A, 5'd0, 32'd8, 32'd2, 4'b0111, 32'd0, 1'b1, 1'b0);
    pop_result();
  endtask

  task automatic test_shift();
    issue(2'b10, 6'h00, 5'd2, 32'hDEAD, 32'd16, 4'b1101, 32'd64, 1'b0, 1'b0);
    total++;
    if (read_data_1 !== 32'd16 || read_data_2 !== 32'd0 || shamt !== 5'd2) begin
      bad++; $display("FAIL shift_steer: rd1=%h rd2=%h shamt=%0d required 10/0/2", read_data_1, read_data_2, shamt);
    end
    pop_result();
    issue(2'b10, 6'h02, 5'd4, 32'd99, 32'd30, 4'b1110, 32'd1, 1'b0, 1'b0);
    pop_result();
    // Non-shift after a shift: shamt must drop back to 0
    issue(2'b11, 6'h00, 5'd9, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0, 1'b0);
    total++;
    if (shamt !== 5'd0 || read_data_1 !== 32'hF0) begin
      bad++; $display("FAIL nonshift_steer: shamt=%0d rd1=%h required 0/f0", shamt, read_data_1);
    end
    pop_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    issue(2'b00, 6'h00, 5'd0, 32'd100, 32'd1, 4'b0010, 32'd101, 1'b0, 1'b0);
    while (!res_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    // Offer the next op while the consumer stalls
    in_valid = 1'b1; in_alu_op = 2'b01; in_funct = 6'h00; in_shamt = 5'd0;
    in_rs_data = 32'd50; in_rt_data = 32'd8;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || res_data !== 32'd101 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold: cyc=%0d valid=%b data=%h in_ready=%b required 1/65/0", c, res_valid, res_data, in_ready);
      end
      total++;
      if (issue_count !== exp_issue) begin
        bad++; $display("FAIL stall_count: got %0d required %0d", issue_count, exp_issue);
      end
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready: got %b required 0", in_ready);
    end
    e = exp_q.pop_front();
    total++;
    if (res_data !== e.d) begin
      bad++; $display("FAIL b2b_first: got %h required %h", res_data, e.d);
    end
    // Pop and accept on the same edge
    res_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
    res_ready = 1'b0; in_valid = 1'b0;
    e.d = 32'd42; e.z = 1'b0; e.il = 1'b0;
    exp_q.push_back(e);
    if (exp_issue != CNT_MAX) exp_issue++;
    total++;
    if (res_valid !== 1'b0 || issue_count !== exp_issue || ALU_control !== 4'b0110) begin
      bad++; $display("FAIL b2b_accept: valid=%b count=%0d ctrl=%b required 0/%0d/0110", res_valid, issue_count, ALU_control, exp_issue);
    end
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_latency: res_valid=%b required 1", res_valid);
    end
    pop_result();
  endtask

  task automatic test_illegal();
    issue(2'b10, 6'h3F, 5'd0, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 1'b1);
    total++;
    if (illegal_count !== 1) begin
      bad++; $display("FAIL illegal_first: got %0d required 1", illegal_count);
    end
    pop_result();
  endtask

  task automatic test_saturation();
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom;
      issue(2'b10, 6'h3E, 5'd0, a, b, 4'b0010, a + b, (a + b) == 32'd0, 1'b1);
      pop_result();
    end
    total++;
    if (issue_count !== CNT_MAX || illegal_count !== CNT_MAX) begin
      bad++; $display("FAIL saturate: %0d/%0d required %0d/%0d", issue_count, illegal_count, CNT_MAX, CNT_MAX);
    end
  endtask

  task automatic test_reset_exec();
    issue(2'b10, 6'h20, 5'd0, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || issue_count !== '0 || illegal_count !== '0) begin
      bad++; $display("FAIL reset_exec: valid=%b ready=%b counts=%0d/%0d required 0/1/0/0", res_valid, in_ready, issue_count, illegal_count);
    end
    exp_q.delete();
    exp_issue = '0; exp_ill = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b00, 6'h00, 5'd0, 32'd40, 32'd2, 4'b0010, 32'd42, 1'b0, 1'b0);
    pop_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_logic();
    test_shift();
    test_back_to_back();
    test_illegal();
    test_saturation();
    test_reset_exec();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover: %0d results required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
